// File: rtl/blink_rate_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : blink_rate_ctrl                                                 |
// | Purpose  : button sync/debounce, 4-mode rate FSM and blink tick generator. |
// |            Optional long-press-to-OFF is enabled by macro LONGPRESS_OFF_EN. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module blink_rate_ctrl #(
    parameter int DEB_CYCLES  = 16,
    parameter int BASE_DIV    = 8,
    parameter int LONG_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    output logic       tick,
    output logic [1:0] mode,
    output logic       press,
    output logic       long_press
);
    localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
    localparam int TICK_W = $clog2(BASE_DIV << 2);

    typedef enum logic [1:0] {
        MODE_FAST = 2'd0,
        MODE_MED  = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_OFF  = 2'd3
    } mode_t;

    if (DEB_CYCLES < 2 || BASE_DIV < 2 || LONG_CYCLES < 1) begin : g_param_check
        $error("blink_rate_ctrl: parameter out of range");
    end

    logic [1:0]        sync_q, sync_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              stable_q, stable_d;
    logic              stable_dly_q, stable_dly_d;
    logic              press_q, press_d;
    mode_t             mode_q, mode_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [TICK_W-1:0] period_m1;
    logic              tick_now;
    logic              mode_change;
    logic              btn_s;

    assign btn_s = sync_q[1];

    // OFF would overflow the counter width here, but it never ticks so it is masked below.
    assign period_m1 = TICK_W'((BASE_DIV << mode_q) - 1);
    assign tick_now  = (mode_q != MODE_OFF) && (tick_cnt_q == period_m1);

`ifdef LONGPRESS_OFF_EN
    localparam int LP_W = $clog2(LONG_CYCLES + 1);
    logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;
    logic            long_press_q, long_press_d;
`endif

    always_comb begin
        sync_d = {sync_q[0], btn_in};

        stable_d  = stable_q;
        deb_cnt_d = '0;
        if (btn_s != stable_q) begin
            if (deb_cnt_q == DEB_W'(DEB_CYCLES)) begin
                stable_d = btn_s;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end

        stable_dly_d = stable_q;
        press_d      = stable_q & ~stable_dly_q;

        mode_d = mode_q;
        if (press_q) begin
            unique case (mode_q)
                MODE_FAST: mode_d = MODE_MED;
                MODE_MED:  mode_d = MODE_SLOW;
                MODE_SLOW: mode_d = MODE_OFF;
                default:   mode_d = MODE_FAST;
            endcase
        end

`ifdef LONGPRESS_OFF_EN
        // Saturates at LONG_CYCLES so one hold produces a single long_press pulse.
        lp_cnt_d = '0;
        if (stable_q) begin
            lp_cnt_d = (lp_cnt_q == LP_W'(LONG_CYCLES)) ? lp_cnt_q : lp_cnt_q + 1'b1;
        end
        long_press_d = stable_q && (lp_cnt_q == LP_W'(LONG_CYCLES - 1));
        if (long_press_q) begin
            mode_d = MODE_OFF;
        end
        mode_change = press_q | long_press_q;
`else
        mode_change = press_q;
`endif

        if (mode_change || (mode_q == MODE_OFF) || tick_now) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q       <= '0;
            deb_cnt_q    <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            press_q      <= 1'b0;
            mode_q       <= MODE_FAST;
            tick_cnt_q   <= '0;
`ifdef LONGPRESS_OFF_EN
            lp_cnt_q     <= '0;
            long_press_q <= 1'b0;
`endif
        end else begin
            sync_q       <= sync_d;
            deb_cnt_q    <= deb_cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            press_q      <= press_d;
            mode_q       <= mode_d;
            tick_cnt_q   <= tick_cnt_d;
`ifdef LONGPRESS_OFF_EN
            lp_cnt_q     <= lp_cnt_d;
            long_press_q <= long_press_d;
`endif
        end
    end

    assign tick  = tick_now;
    assign mode  = mode_q;
    assign press = press_q;
`ifdef LONGPRESS_OFF_EN
    assign long_press = long_press_q;
`else
    assign long_press = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_blink_rate_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_blink_rate_ctrl                                              |
// | Purpose  : directed self-checking bench for blink_rate_ctrl (4/8/32 cfg).  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_blink_rate_ctrl;
    logic       clk;
    logic       reset;
    logic       btn_in;
    logic       tick;
    logic [1:0] mode;
    logic       press;
    logic       long_press;

    int checks   = 0;
    int failures = 0;

    blink_rate_ctrl #(
        .DEB_CYCLES (4),
        .BASE_DIV   (8),
        .LONG_CYCLES(32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .tick      (tick),
        .mode      (mode),
        .press     (press),
        .long_press(long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic       btn_after;
        logic       tick;
        logic [1:0] mode;
        logic       press;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves time 3 units after an edge; the next edge is cycle n=1 in every test.
    task automatic do_reset();
        btn_in = 1'b0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
    endtask

    // Button high at n=0, released after n=20; new mode appears at n=9.
    task automatic press_button(output int n_press, output int n_long);
        n_press = 0;
        n_long  = 0;
        btn_in  = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            step();
            if (press) n_press++;
            if (long_press) n_long++;
            if (n == 20) btn_in = 1'b0;
        end
    endtask

    initial begin
        int idx, np, nl, bad;

        vecs[0]  = '{7,  1'b1, 1'b1, 2'd0, 1'b0};
        vecs[1]  = '{8,  1'b1, 1'b0, 2'd0, 1'b1};
        vecs[2]  = '{9,  1'b1, 1'b0, 2'd1, 1'b0};
        vecs[3]  = '{10, 1'b1, 1'b0, 2'd1, 1'b0};
        vecs[4]  = '{20, 1'b0, 1'b0, 2'd1, 1'b0};
        vecs[5]  = '{23, 1'b0, 1'b0, 2'd1, 1'b0};
        vecs[6]  = '{24, 1'b0, 1'b1, 2'd1, 1'b0};
        vecs[7]  = '{25, 1'b0, 1'b0, 2'd1, 1'b0};
        vecs[8]  = '{30, 1'b0, 1'b0, 2'd1, 1'b0};
        vecs[9]  = '{39, 1'b0, 1'b0, 2'd1, 1'b0};
        vecs[10] = '{40, 1'b0, 1'b1, 2'd1, 1'b0};
        vecs[11] = '{56, 1'b0, 1'b1, 2'd1, 1'b0};

        // Reset state, then free-running mode-0 ticks
        reset  = 1'b1;
        btn_in = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("reset_tick", tick, 0);
        check("reset_mode", mode, 0);
        check("reset_press", press, 0);
        check("reset_long", long_press, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        bad = 0;
        for (int n = 1; n <= 55; n++) begin
            step();
            if (tick !== ((n % 8) == 7)) bad++;
            if (mode !== 2'd0 || press !== 1'b0) bad++;
        end
        check("mode0_tick_period_errors", bad, 0);
        check("tick_high_before_async", tick, 1);
        #2 reset = 1'b0;
        #1;
        check("async_reset_tick", tick, 0);
        check("async_reset_mode", mode, 0);
        check("async_reset_press", press, 0);

        // Short glitch and fast toggling must never be accepted
        #2 reset = 1'b1;
        np = 0;
        btn_in = 1'b1;
        repeat (3) step();
        btn_in = 1'b0;
        repeat (20) begin step(); if (press) np++; end
        check("glitch_3cyc_presses", np, 0);
        for (int i = 0; i < 40; i++) begin
            btn_in = ~btn_in;
            step();
            if (press) np++;
        end
        btn_in = 1'b0;
        repeat (20) begin step(); if (press) np++; end
        check("toggle_presses", np, 0);
        check("glitch_mode", mode, 0);

        // Clean press, table driven
        do_reset();
        btn_in = 1'b1;
        idx = 0;
        for (int n = 1; n <= 56; n++) begin
            step();
            if (idx < NV && vecs[idx].n == n) begin
                check($sformatf("clean_n%0d_tick", n), tick, vecs[idx].tick);
                check($sformatf("clean_n%0d_mode", n), mode, vecs[idx].mode);
                check($sformatf("clean_n%0d_press", n), press, vecs[idx].press);
                btn_in = vecs[idx].btn_after;
                idx++;
            end
        end
        check("clean_rows_applied", idx, NV);

        // Wrap through OFF
        do_reset();
        press_button(np, nl);
        check("wrap_press1_mode", mode, 1);
        check("wrap_press1_count", np, 1);
        press_button(np, nl);
        check("wrap_press2_mode", mode, 2);
        press_button(np, nl);
        check("wrap_press3_mode", mode, 3);
        bad = 0;
        repeat (100) begin step(); if (tick !== 1'b0 || mode !== 2'd3) bad++; end
        check("off_tick_errors", bad, 0);
        press_button(np, nl);
        check("wrap_press4_mode", mode, 0);
        bad = 0;
        for (int n = 31; n <= 48; n++) begin
            step();
            if (tick !== (((n - 9) % 8) == 7)) bad++;
        end
        check("wrap_mode0_tick_errors", bad, 0);

        // Press lands exactly on count==P-1
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            step();
            if (n == 7) btn_in = 1'b1;
            if (n == 27) btn_in = 1'b0;
            if (n == 15) begin
                check("boundary_tick", tick, 1);
                check("boundary_press", press, 1);
                check("boundary_mode_before", mode, 0);
            end
            if (n == 16) begin
                check("boundary_mode_after", mode, 1);
                check("boundary_no_tick_after", tick, 0);
            end
            if (n == 30) check("boundary_n30_tick", tick, 0);
            if (n == 31) check("boundary_n31_tick", tick, 1);
        end

        // Long hold from mode 1
        do_reset();
        press_button(np, nl);
        check("long_start_mode", mode, 1);
        np = 0;
        nl = 0;
        btn_in = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            step();
            if (press) np++;
            if (long_press) nl++;
            if (n == 60) btn_in = 1'b0;
        end
        check("long_press_count", np, 1);
`ifdef LONGPRESS_OFF_EN
        check("long_pulse_count", nl, 1);
        check("long_final_mode", mode, 3);
        check("long_final_tick", tick, 0);
`else
        check("long_pulse_count", nl, 0);
        check("long_final_mode", mode, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
